// File: rtl/calc_pkg.sv
// calc_pkg: entry states, stage LED codes and op-code constants shared with the calculator
package calc_pkg;
  typedef enum logic [2:0] {ENTER_A, ENTER_B, ENTER_OP, ISSUE, HOLD} entry_st_t;
  localparam logic [1:0] STG_A = 2'd0;
  localparam logic [1:0] STG_B = 2'd1;
  localparam logic [1:0] STG_OP = 2'd2;
  localparam logic [1:0] STG_HOLD = 2'd3;
  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_AND = 2;
  localparam int OP_OR = 3;
  localparam int OP_XOR = 4;
  localparam int OP_NOT = 5;
  localparam int OP_SHL = 6;
  localparam int OP_SHR = 7;
  localparam int OP_MUL = 8;
  localparam int OP_CMP = 9;
  localparam int NUM_OPS_DEF = 10;
  function automatic logic [1:0] stage_of(entry_st_t s);
    return s == ENTER_A ? STG_A : s == ENTER_B ? STG_B : s == ENTER_OP ? STG_OP : STG_HOLD;
  endfunction
endpackage

// File: rtl/calc_btn_debounce.sv
// calc_btn_debounce: 2-FF synchronizer, stability filter and rising-edge press pulse
// Ports: clk, rst (async active-low), i_btn raw button, o_press one-cycle pulse per accepted press.
module calc_btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LP_LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic r_s1, r_s2, r_lvl, r_lvl_q;
  logic [CW-1:0] r_cnt;
  logic w_diff, w_hit;
  assign w_diff = r_s2 ^ r_lvl;
  // the DEBOUNCE_CYCLES-th consecutive differing cycle flips the filtered level
  assign w_hit = w_diff && r_cnt == LP_LAST;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_lvl <= 1'b0;
      r_lvl_q <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_s1 <= i_btn;
      r_s2 <= r_s1;
      r_lvl <= r_lvl ^ w_hit;
      r_lvl_q <= r_lvl;
      r_cnt <= (w_diff && !w_hit) ? r_cnt + 1'b1 : '0;
    end
  assign o_press = r_lvl & ~r_lvl_q;
endmodule

// File: rtl/calc_operand_loader.sv
// calc_operand_loader: debounced button entry FSM capturing operand A, operand B and op select
// Ports: clk, rst (async active-low), sw raw switches, btn_next/btn_clear raw buttons,
// A/B/sel registered operands, issue one-cycle strobe, stage LED code, op_err sticky illegal-op flag.
module calc_operand_loader
  import calc_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int NUM_OPS = NUM_OPS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn_next,
  input  logic             btn_clear,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] sel,
  output logic             issue,
  output logic [1:0]       stage,
  output logic             op_err
);
  localparam logic [WIDTH:0] LP_NOPS = NUM_OPS[WIDTH:0];
  entry_st_t r_st, w_st;
  logic [WIDTH-1:0] r_sw1, r_sw2, r_a, r_b, r_sel, w_a, w_b, w_sel;
  logic r_err, w_err, w_np, w_cp, w_legal;
  calc_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
    .clk(clk), .rst(rst), .i_btn(btn_next), .o_press(w_np));
  calc_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .clk(clk), .rst(rst), .i_btn(btn_clear), .o_press(w_cp));
  assign w_legal = {1'b0, r_sw2} < LP_NOPS;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_sw1 <= '0;
      r_sw2 <= '0;
      r_st <= ENTER_A;
      r_a <= '0;
      r_b <= '0;
      r_sel <= '0;
      r_err <= 1'b0;
    end else begin
      r_sw1 <= sw;
      r_sw2 <= r_sw1;
      r_st <= w_st;
      r_a <= w_a;
      r_b <= w_b;
      r_sel <= w_sel;
      r_err <= w_err;
    end
  // clear takes priority over a coincident next press, which is then dropped
  always_comb begin
    w_st = r_st;
    w_a = r_a;
    w_b = r_b;
    w_sel = r_sel;
    w_err = r_err;
    if (w_cp) begin
      w_st = ENTER_A;
      w_a = '0;
      w_b = '0;
      w_sel = '0;
      w_err = 1'b0;
    end else if (w_np || r_st == ISSUE) begin
      case (r_st)
        ENTER_A: begin
          w_a = r_sw2;
          w_err = 1'b0;
          w_st = ENTER_B;
        end
        ENTER_B: begin
          w_b = r_sw2;
          w_err = 1'b0;
          w_st = ENTER_OP;
        end
        ENTER_OP: begin
          w_sel = w_legal ? r_sw2 : r_sel;
          w_err = !w_legal;
          w_st = w_legal ? ISSUE : ENTER_OP;
        end
        ISSUE: w_st = HOLD;
        HOLD: begin
          w_err = 1'b0;
          w_st = ENTER_A;
        end
        default: w_st = ENTER_A;
      endcase
    end
  end
  assign A = r_a;
  assign B = r_b;
  assign sel = r_sel;
  assign op_err = r_err;
  assign issue = r_st == ISSUE;
  assign stage = stage_of(r_st);
endmodule

// File: tb/tb_calc_operand_loader.sv
// tb_calc_operand_loader: scoreboard bench with an abstract entry model and random stimulus
`timescale 1ns/1ps
module tb_calc_operand_loader;
  localparam int D = 4;
  logic clk = 1'b0, rst = 1'b0, btn_next = 1'b0, btn_clear = 1'b0;
  logic [3:0] sw = '0;
  logic [3:0] A, B, sel;
  logic issue, op_err;
  logic [1:0] stage;
  int n_chk = 0, n_bad = 0, n_issue = 0;
  int q[$];
  int m_st = 0;
  logic [3:0] m_a = '0, m_b = '0, m_sel = '0;
  logic m_err = 1'b0;
  bit prev_issue = 0;

  calc_operand_loader #(.WIDTH(4), .DEBOUNCE_CYCLES(D), .NUM_OPS(10)) dut (
    .clk(clk), .rst(rst), .sw(sw), .btn_next(btn_next), .btn_clear(btn_clear),
    .A(A), .B(B), .sel(sel), .issue(issue), .stage(stage), .op_err(op_err));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string n, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s act=%0d exp=%0d", n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && issue) begin
      n_issue++;
      chk("issue_width", int'(prev_issue), 0);
      if (q.size() == 0) chk("issue_unexpected", 1, q.size());
      else chk("issue_abs", int'({A, B, sel}), q.pop_front());
    end
    prev_issue = rst && issue;
  end

  task automatic m_reset();
    m_st = 0; m_a = '0; m_b = '0; m_sel = '0; m_err = 1'b0;
  endtask

  task automatic m_next(input logic [3:0] v);
    if (m_st == 0) begin m_a = v; m_err = 1'b0; m_st = 1; end
    else if (m_st == 1) begin m_b = v; m_err = 1'b0; m_st = 2; end
    else if (m_st == 2) begin
      if (v < 10) begin
        m_sel = v; m_err = 1'b0; m_st = 3;
        q.push_back(int'({m_a, m_b, m_sel}));
      end else m_err = 1'b1;
    end else begin m_err = 1'b0; m_st = 0; end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_stage"}, stage, m_st);
    chk({tag, "_A"}, A, m_a);
    chk({tag, "_B"}, B, m_b);
    chk({tag, "_sel"}, sel, m_sel);
    chk({tag, "_err"}, op_err, m_err);
  endtask

  // kind: 0 next, 1 clear, 2 both together
  task automatic act(input logic [3:0] v, input int kind);
    @(posedge clk); #1 sw = v;
    repeat (3) @(posedge clk);
    #1;
    if (kind == 0) m_next(v); else m_reset();
    btn_next = kind != 1;
    btn_clear = kind != 0;
    repeat (D + 8) @(posedge clk);
    #1 btn_next = 1'b0; btn_clear = 1'b0;
    repeat (D + 8) @(posedge clk);
    @(negedge clk);
    check_all(kind == 0 ? "next" : kind == 1 ? "clear" : "both");
  endtask

  initial begin
    int k;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_A", A, 0); chk("rst_B", B, 0); chk("rst_sel", sel, 0);
    chk("rst_stage", stage, 0); chk("rst_issue", issue, 0); chk("rst_err", op_err, 0);
    @(negedge clk) rst = 1'b1;
    repeat (100) @(posedge clk);
    @(negedge clk);
    chk("idle_issue", n_issue, 0);
    chk("idle_stage", stage, 0);
    @(posedge clk); #1 sw = 4'h9;
    repeat (4) @(posedge clk);
    #1 btn_next = 1'b1;
    @(posedge clk); #1 btn_next = 1'b0;
    repeat (10) @(posedge clk);
    #1 btn_next = 1'b1;
    repeat (3) @(posedge clk);
    #1 btn_next = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("glitch_stage", stage, 0);
    @(posedge clk); #1 btn_next = 1'b1;
    m_next(4'h9);
    k = 0;
    for (int i = 1; i <= 20 && k == 0; i++) begin
      @(posedge clk); #1;
      if (stage == 2'd1) k = i;
    end
    chk("latency", k, D + 3);
    repeat (20 - k) @(posedge clk);
    #1 btn_next = 1'b0;
    repeat (D + 8) @(posedge clk);
    @(negedge clk);
    check_all("hold_once");
    act(4'h3, 0); act(4'hD, 0); act(4'h0, 0); act(4'h3, 0);
    act(4'h3, 0); act(4'h8, 0); act(4'hF, 0); act(4'h2, 0); act(4'h0, 0);
    act(4'h7, 0); act(4'h0, 1); act(4'h5, 2);
    act(4'h1, 0); act(4'h2, 0);
    @(posedge clk); #3 rst = 1'b0;
    m_reset();
    #1;
    check_all("async_rst");
    @(negedge clk) rst = 1'b1;
    act(4'h6, 0); act(4'h7, 0); act(4'h8, 0);
    repeat (30) begin
      int r;
      r = $urandom_range(0, 9);
      act(4'($urandom_range(0, 15)), r == 0 ? 1 : r == 1 ? 2 : 0);
    end
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("q_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
